sram_controller: RTL and testbench

Sequences every load and store from the MEM stage onto a 16-bit-wide external SRAM, splitting each 32-bit word into two half-word accesses with programmable wait states. It maps the ALU byte address into the SRAM word space (base 1024, word-aligned) and drives the stage's freeze so the pipeline stalls until the access completes. It sits between the MEM stage and the board SRAM pins, replacing the single-cycle data memory.

---
 rtl/sram_controller.sv | 134 +++++++++++++
 tb/tb_sram_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// sram_controller
//   Runs each MEM-stage load/store as two half-word accesses on a 16-bit
//   external SRAM. The low half-word goes first, then the high half-word.
//   Each half-word phase lasts WAIT_CYCLES+1 cycles. The byte address is
//   rebased by BASE_ADDR and turned into an SRAM word index.
//
//   Handshake: the pipeline holds rd_en/wr_en (and address/write_data)
//   stable while frozen. The freeze is (rd_en|wr_en) & ~ready. ready is
//   high when no request is pending, or in the single DONE cycle. The
//   pipeline advances on the edge that ends DONE, so a request is consumed
//   exactly once.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   rd_en, wr_en      load / store request (write wins if both are high)
//   address           byte address; bits [1:0] are ignored
//   write_data        store value
//   read_data         load result; holds until the next load completes
//   ready             completion / not-busy indication
//   sram_addr         half-word address to the SRAM
//   sram_we_n         SRAM write strobe, active-low
//   sram_dq_oe        output enable for the data pins
//   sram_dq_out       write data to the pins
//   sram_dq_in        read data from the pins
//   dbg_state         current FSM state (0 idle, 1 lo, 2 hi, 3 done)
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic        sram_we_n,
  output logic        sram_dq_oe,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  wait_cnt;
  logic [16:0] word_q;
  logic [31:0] wdata_q;
  logic        op_wr_q;

  logic        req;
  logic        phase_last;
  logic [31:0] offset;
  logic        unused_offset_bits;

  assign req        = rd_en | wr_en;
  assign phase_last = (wait_cnt == LAST_CNT);
  // Rebase and drop the byte offset. The subtraction wraps and is not
  // range-checked. Only 17 word bits reach the 18-bit half-word address.
  assign offset             = address - BASE_ADDR;
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
  assign dbg_state          = state;

  // Next-state logic and all pin outputs. Outputs are decoded from state
  // alone, so an asynchronous reset returns the pins to idle immediately.
  always_comb begin
    state_nxt   = state;
    ready       = 1'b0;
    sram_addr   = 18'd0;
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_dq_out = 16'd0;
    case (state)
      S_IDLE: begin
        ready = ~req;
        if (req) state_nxt = S_LO;
      end
      S_LO, S_HI: begin
        sram_addr  = {word_q, (state == S_HI)};
        sram_dq_oe = op_wr_q;
        // The strobe rises on the last cycle of a phase. The address and
        // data stay stable across that rising edge.
        sram_we_n  = ~(op_wr_q & ~phase_last);
        if (op_wr_q) sram_dq_out = (state == S_HI) ? wdata_q[31:16] : wdata_q[15:0];
        if (phase_last) state_nxt = (state == S_LO) ? S_HI : S_DONE;
      end
      S_DONE: begin
        ready     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      word_q    <= 17'd0;
      wdata_q   <= 32'd0;
      op_wr_q   <= 1'b0;
      read_data <= 32'd0;
    end else begin
      state <= state_nxt;
      // The counter restarts on every state change, which covers entry to
      // both LO and HI.
      if (state_nxt != state) wait_cnt <= 4'd0;
      else if (state == S_LO || state == S_HI) wait_cnt <= wait_cnt + 4'd1;

      if (state == S_IDLE && req) begin
        word_q  <= offset[18:2];
        wdata_q <= write_data;
        op_wr_q <= wr_en;
      end

      if (!op_wr_q && phase_last) begin
        if (state == S_LO) read_data[15:0]  <= sram_dq_in;
        if (state == S_HI) read_data[31:16] <= sram_dq_in;
      end
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller. dut1 runs with WAIT_CYCLES=1 and is backed by a
// pin-level SRAM model. dut3 runs with WAIT_CYCLES=3 and reads a fixed
// address-derived pattern. The shared request signals are routed to
// whichever instance sel3 selects.
module tb_sram_controller;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus signals ----------------
  logic        sel3 = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] write_data = 32'd0;

  logic        rd_en1, wr_en1, rd_en3, wr_en3;
  assign rd_en1 = rd_en & ~sel3;
  assign wr_en1 = wr_en & ~sel3;
  assign rd_en3 = rd_en & sel3;
  assign wr_en3 = wr_en & sel3;

  logic [31:0] read_data1, read_data3;
  logic        ready1, ready3, we_n1, we_n3, oe1, oe3;
  logic [17:0] sram_addr1, sram_addr3;
  logic [15:0] dq_out1, dq_out3, dq_in1, dq_in3;
  logic [1:0]  dbg1, dbg3;

  sram_controller #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_en1), .wr_en(wr_en1),
    .address(address), .write_data(write_data), .read_data(read_data1),
    .ready(ready1), .sram_addr(sram_addr1), .sram_we_n(we_n1),
    .sram_dq_oe(oe1), .sram_dq_out(dq_out1), .sram_dq_in(dq_in1),
    .dbg_state(dbg1)
  );

  sram_controller #(.WAIT_CYCLES(3), .BASE_ADDR(32'd1024)) dut3 (
    .clk(clk), .rst(rst), .rd_en(rd_en3), .wr_en(wr_en3),
    .address(address), .write_data(write_data), .read_data(read_data3),
    .ready(ready3), .sram_addr(sram_addr3), .sram_we_n(we_n3),
    .sram_dq_oe(oe3), .sram_dq_out(dq_out3), .sram_dq_in(dq_in3),
    .dbg_state(dbg3)
  );

  // Monitored view of the selected instance.
  logic [31:0] m_read_data;
  logic        m_ready, m_we_n, m_oe;
  logic [17:0] m_addr;
  logic [15:0] m_dq_out;
  logic [1:0]  m_dbg;
  assign m_read_data = sel3 ? read_data3 : read_data1;
  assign m_ready     = sel3 ? ready3 : ready1;
  assign m_we_n      = sel3 ? we_n3 : we_n1;
  assign m_oe        = sel3 ? oe3 : oe1;
  assign m_addr      = sel3 ? sram_addr3 : sram_addr1;
  assign m_dq_out    = sel3 ? dq_out3 : dq_out1;
  assign m_dbg       = sel3 ? dbg3 : dbg1;

  // ---------------- SRAM model for dut1 ----------------
  // A write commits when the strobe is seen rising, using the address and
  // data observed while it was low.
  logic [15:0] mem1 [0:1023];
  logic        pend_v = 1'b0;
  logic [9:0]  pend_a;
  logic [15:0] pend_d;
  initial for (int i = 0; i < 1024; i++) mem1[i] = 16'h0000;
  assign dq_in1 = oe1 ? 16'h0000 : mem1[sram_addr1[9:0]];
  always @(negedge clk) begin
    if (!we_n1) begin
      pend_v = 1'b1;
      pend_a = sram_addr1[9:0];
      pend_d = dq_out1;
    end else if (pend_v) begin
      mem1[pend_a] = pend_d;
      pend_v = 1'b0;
    end
  end

  // dut3 sees a pattern that depends only on the half-word address.
  assign dq_in3 = sram_addr3[15:0] ^ 16'hA5C3;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = 32'd0;
  int          n_vec = 0;
  int          n_err = 0;
  int          ready_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drives one request starting in the current (idle) cycle and checks
  // every cycle through DONE. This is called just after a rising edge.
  task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] data, input int w, input bit drop,
                        input logic [31:0] exp_rd);
    logic [31:0] word;
    int          ph;
    bit          last, e_oe;
    logic [17:0] e_addr;
    logic [15:0] e_dq;
    logic [31:0] popped;
    wr_en = wr; rd_en = rd; address = addr; write_data = data;
    if (!wr) exp_q.push_back(exp_rd);
    word = (addr - 32'd1024) >> 2;
    for (int c = 0; c <= 2*w + 3; c++) begin
      @(negedge clk);
      if (c == 0) ph = 0;
      else if (c <= w + 1) ph = 1;
      else if (c <= 2*w + 2) ph = 2;
      else ph = 3;
      last   = (ph == 1 && c == w + 1) || (ph == 2 && c == 2*w + 2);
      e_addr = (ph == 1) ? {word[16:0], 1'b0} : (ph == 2) ? {word[16:0], 1'b1} : 18'd0;
      e_oe   = wr && (ph == 1 || ph == 2);
      e_dq   = !e_oe ? 16'h0000 : (ph == 1) ? data[15:0] : data[31:16];
      check("ready", 32'(m_ready), 32'(ph == 3));
      check("sram_addr", 32'(m_addr), 32'(e_addr));
      check("sram_we_n", 32'(m_we_n), 32'(!(e_oe && !last)));
      check("sram_dq_oe", 32'(m_oe), 32'(e_oe));
      check("sram_dq_out", 32'(m_dq_out), 32'(e_dq));
      check("state", 32'(m_dbg), 32'(ph));
      if (ph == 3) begin
        ready_cyc = cyc;
        if (!wr) begin
          if (exp_q.size() == 0) check("exp_q_empty", 32'd1, 32'd0);
          else begin
            popped = exp_q.pop_front();
            check("read_data", m_read_data, popped);
            last_rd = popped;
          end
        end else begin
          check("read_data_hold", m_read_data, last_rd);
        end
      end
    end
    @(posedge clk); #1;
    if (drop) begin rd_en = 1'b0; wr_en = 1'b0; end
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] ra, rdat;
  int          first_rdy;

  initial begin
    // Reset values while held in reset.
    #3;
    check("rst_ready", 32'(ready1), 32'd1);
    check("rst_read_data", read_data1, 32'd0);
    check("rst_we_n", 32'(we_n1), 32'd1);
    check("rst_state", 32'(dbg1), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Idle: nothing is requested and the pins stay quiet.
    repeat (4) begin
      @(negedge clk);
      check("idle_ready", 32'(ready1), 32'd1);
      check("idle_we_n", 32'(we_n1), 32'd1);
      check("idle_oe", 32'(oe1), 32'd0);
      check("idle_addr", 32'(sram_addr1), 32'd0);
    end
    @(posedge clk); #1;

    // Write then read back.
    access(1, 0, 32'd1028, 32'hDEADBEEF, 1, 1, 32'd0);
    check("mem_hw2", 32'(mem1[2]), 32'h0000BEEF);
    check("mem_hw3", 32'(mem1[3]), 32'h0000DEAD);
    access(0, 1, 32'd1028, 32'd0, 1, 1, 32'hDEADBEEF);

    // Back-to-back: the read is presented in the idle cycle after DONE.
    access(1, 0, 32'd1024, 32'h12345678, 1, 0, 32'd0);
    first_rdy = ready_cyc;
    access(0, 1, 32'd1024, 32'd0, 1, 1, 32'h12345678);
    check("b2b_gap", 32'(ready_cyc - first_rdy), 32'd6);

    // Both strobes high: treated as a write, read_data untouched.
    access(1, 1, 32'd1032, 32'hA5A55A5A, 1, 1, 32'd0);
    check("prio_hw4", 32'(mem1[4]), 32'h00005A5A);
    check("prio_hw5", 32'(mem1[5]), 32'h0000A5A5);
    access(0, 1, 32'd1032, 32'd0, 1, 1, 32'hA5A55A5A);

    // Random write/read pairs; the low address bits must be ignored.
    for (int i = 0; i < 4; i++) begin
      ra   = 32'd1024 + 32'($urandom_range(8, 63)) * 4;
      rdat = $urandom;
      access(1, 0, ra + 32'($urandom_range(0, 3)), rdat, 1, 1, 32'd0);
      access(0, 1, ra + 32'($urandom_range(0, 3)), 32'd0, 1, 1, rdat);
    end

    // Reset during HI of a write, with the request held throughout.
    wr_en = 1'b1; rd_en = 1'b0; address = 32'd1036; write_data = 32'h0BADCAFE;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_we_n", 32'(we_n1), 32'd0);
    check("pre_rst_addr", 32'(sram_addr1), 32'd7);
    #1 rst = 1'b0;
    #1;
    check("arst_we_n", 32'(we_n1), 32'd1);
    check("arst_addr", 32'(sram_addr1), 32'd0);
    check("arst_oe", 32'(oe1), 32'd0);
    check("arst_dq_out", 32'(dq_out1), 32'd0);
    check("arst_read_data", read_data1, 32'd0);
    check("arst_ready", 32'(ready1), 32'd0);
    check("arst_state", 32'(dbg1), 32'd0);
    last_rd = 32'd0;
    @(posedge clk); #1;
    rst = 1'b1;
    access(1, 0, 32'd1036, 32'h0BADCAFE, 1, 1, 32'd0);
    check("rst_hw6", 32'(mem1[6]), 32'h0000CAFE);
    check("rst_hw7", 32'(mem1[7]), 32'h00000BAD);

    // Wait states: WAIT_CYCLES=3, read of 2044 hits half-words 510 and 511.
    sel3 = 1'b1;
    #1;
    access(0, 1, 32'd2044, 32'd0, 3, 1, {16'd511 ^ 16'hA5C3, 16'd510 ^ 16'hA5C3});
    sel3 = 1'b0;

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
